// File: rtl/bcd_up_counter_2d.sv
// Two-digit BCD up-counter with a start/stop push-button FSM (IDLE/RUN/STOP),
// synchronous clear and a one-cycle carry pulse on wrap at {MAX_TENS,MAX_UNITS}.
module bcd_up_counter_2d #(
  parameter logic [3:0] MAX_TENS  = 4'd9,
  parameter logic [3:0] MAX_UNITS = 4'd9
) (
  input  logic       clk,
  input  logic       r,
  input  logic       start_stop,
  input  logic       tick,
  input  logic       clr,
  output logic [3:0] out_units,
  output logic [3:0] out_tens,
  output logic       carry,
  output logic       running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  logic       s1_q, s2_q, s3_q;
  logic [1:0] warm_q;
  state_t     state_q, state_d;
  logic [3:0] units_q, units_d;
  logic [3:0] tens_q, tens_d;
  logic       carry_q, carry_d;
  logic       running_q, running_d;
  logic       ss_edge;
  logic       at_term;

  // s3 holds a genuine sample only from the third clk after reset release;
  // before that its reset zero would fake an edge for a button held through r.
  assign ss_edge = s2_q & ~s3_q & (warm_q == 2'd3);
  assign at_term = (tens_q == MAX_TENS) && (units_q == MAX_UNITS);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    units_d = units_q;
    tens_d  = tens_q;
    carry_d = 1'b0;
    if (clr) begin
      state_d = IDLE;
      units_d = 4'd0;
      tens_d  = 4'd0;
    end else begin
      // Tick is judged against the pre-transition state.
      if (state_q == RUN && tick) begin
        if (at_term) begin
          units_d = 4'd0;
          tens_d  = 4'd0;
          carry_d = 1'b1;
        end else if (units_q == 4'd9) begin
          units_d = 4'd0;
          tens_d  = tens_q + 4'd1;
        end else begin
          units_d = units_q + 4'd1;
        end
      end
      if (ss_edge) begin
        case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = STOP;
          STOP:    state_d = RUN;
          default: state_d = IDLE;
        endcase
      end
    end
    running_d = (state_d == RUN);
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values,
  // which is what makes the s1->s2->s3 chain a true shift register.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      warm_q    <= 2'd0;
      state_q   <= IDLE;
      units_q   <= 4'd0;
      tens_q    <= 4'd0;
      carry_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      s1_q      <= start_stop;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
      state_q   <= state_d;
      units_q   <= units_d;
      tens_q    <= tens_d;
      carry_q   <= carry_d;
      running_q <= running_d;
    end
  end

  assign out_units = units_q;
  assign out_tens  = tens_q;
  assign carry     = carry_q;
  assign running   = running_q;

endmodule

// File: tb/tb_bcd_up_counter_2d.sv
// Scoreboard bench for bcd_up_counter_2d: three parameterisations share one
// stimulus stream; an integer-count reference model predicts every cycle.
module tb_bcd_up_counter_2d;

  typedef struct packed {
    logic [3:0] t;
    logic [3:0] u;
    logic       c;
    logic       run;
  } exp_t;

  localparam int NI = 3;
  int mt[NI] = '{9, 5, 0};
  int mu[NI] = '{9, 9, 7};

  logic clk = 1'b0;
  logic r = 1'b0;
  logic start_stop = 1'b0;
  logic tick = 1'b0;
  logic clr = 1'b0;
  logic [3:0] ou[NI];
  logic [3:0] ot[NI];
  logic       cy[NI];
  logic       rn[NI];

  int errors = 0;
  int checks = 0;

  exp_t sb[NI][$];
  int   mcnt[NI];
  int   mstate[NI];  // 0 = IDLE, 1 = RUN, 2 = STOP
  bit   hist[$];     // start_stop value sampled at each clk since reset release
  int   ncyc;

  always #5 clk = ~clk;

  bcd_up_counter_2d #(.MAX_TENS(4'd9), .MAX_UNITS(4'd9)) u_d99 (
    .clk(clk), .r(r), .start_stop(start_stop), .tick(tick), .clr(clr),
    .out_units(ou[0]), .out_tens(ot[0]), .carry(cy[0]), .running(rn[0]));
  bcd_up_counter_2d #(.MAX_TENS(4'd5), .MAX_UNITS(4'd9)) u_d59 (
    .clk(clk), .r(r), .start_stop(start_stop), .tick(tick), .clr(clr),
    .out_units(ou[1]), .out_tens(ot[1]), .carry(cy[1]), .running(rn[1]));
  bcd_up_counter_2d #(.MAX_TENS(4'd0), .MAX_UNITS(4'd7)) u_d07 (
    .clk(clk), .r(r), .start_stop(start_stop), .tick(tick), .clr(clr),
    .out_units(ou[2]), .out_tens(ot[2]), .carry(cy[2]), .running(rn[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    ncyc = 0;
    for (int k = 0; k < NI; k++) begin
      mcnt[k] = 0;
      mstate[k] = 0;
      sb[k].delete();
    end
  endtask

  // One clk of the reference: a press acts two samples after it is first seen
  // high, provided the sample before that was low.
  task automatic model_step(input bit ss, input bit tk, input bit cl);
    bit   edge_seen;
    bit   cflag;
    exp_t e;
    hist.push_back(ss);
    edge_seen = (ncyc >= 3) && hist[ncyc-2] && !hist[ncyc-3];
    for (int k = 0; k < NI; k++) begin
      cflag = 1'b0;
      if (cl) begin
        mcnt[k] = 0;
        mstate[k] = 0;
      end else begin
        if (mstate[k] == 1 && tk) begin
          if (mcnt[k] == mt[k] * 10 + mu[k]) begin
            mcnt[k] = 0;
            cflag = 1'b1;
          end else begin
            mcnt[k] = mcnt[k] + 1;
          end
        end
        if (edge_seen) mstate[k] = (mstate[k] == 1) ? 2 : 1;
      end
      e.t   = 4'(mcnt[k] / 10);
      e.u   = 4'(mcnt[k] % 10);
      e.c   = cflag;
      e.run = (mstate[k] == 1);
      sb[k].push_back(e);
    end
    ncyc++;
  endtask

  // Entered between negedge+1 and the next posedge; leaves at negedge+1.
  task automatic cycle(input bit ss, input bit tk, input bit cl);
    start_stop = ss;
    tick = tk;
    clr = cl;
    @(posedge clk);
    model_step(ss, tk, cl);
    @(negedge clk);
    #1;
  endtask

  task automatic press();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0);
  endtask

  // Async reset pulse entirely between two clk edges.
  task automatic do_reset(input bit hold_ss);
    #1;
    start_stop = hold_ss;
    tick = 1'b1;
    r = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_units%0d", k), 32'(ou[k]), 32'd0);
      check($sformatf("rst_tens%0d", k), 32'(ot[k]), 32'd0);
      check($sformatf("rst_carry%0d", k), 32'(cy[k]), 32'd0);
      check($sformatf("rst_running%0d", k), 32'(rn[k]), 32'd0);
    end
    #1;
    r = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      if (sb[k].size() > 0) begin
        e = sb[k].pop_front();
        check($sformatf("inst%0d_tens_units_carry_running", k),
              32'({ot[k], ou[k], cy[k], rn[k]}), 32'(e));
      end
    end
  end

  initial begin
    model_reset();
    #1 r = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("init_rst_units%0d", k), 32'(ou[k]), 32'd0);
      check($sformatf("init_rst_running%0d", k), 32'(rn[k]), 32'd0);
    end
    @(negedge clk);
    #1 r = 1'b0;

    // Ticks before any press are ignored; then press and count ten.
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    press();
    ticks(10);

    // Through all three terminal counts, including 99 -> 00.
    ticks(100);

    // Hold at 37 and resume.
    cycle(1'b0, 1'b0, 1'b1);
    press();
    ticks(37);
    press();
    ticks(5);
    press();
    ticks(1);

    // clr together with tick and a press edge at 42.
    cycle(1'b0, 1'b0, 1'b1);
    press();
    ticks(42);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);

    // Async reset at 85 with the button held through release.
    cycle(1'b0, 1'b0, 1'b1);
    press();
    ticks(85);
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
    press();
    ticks(5);

    // Random traffic.
    for (int i = 0; i < 900; i++)
      cycle(($urandom % 25) == 0, $urandom % 2, ($urandom % 90) == 0);

    cycle(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++)
      check($sformatf("drain%0d", k), 32'(sb[k].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_up_counter_2d.md
BCD_UP_COUNTER_2D -- requirements
Module: bcd_up_counter_2d

Interface
REQ-001 SHALL have parameter MAX_TENS, default 4'd9, tens digit of the terminal count (0-9).
REQ-002 SHALL have parameter MAX_UNITS, default 4'd9, units digit of the terminal count (0-9).
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port r  input  1  asynchronous reset, active-high.
REQ-006 SHALL have port start_stop  input  1  asynchronous push-button; each rising edge toggles run/hold.
REQ-007 SHALL have port tick  input  1  single-cycle count strobe, synchronous to clk.
REQ-008 SHALL have port clr  input  1  synchronous clear, active-high.
REQ-009 SHALL have port out_units  output  4  BCD units digit.
REQ-010 SHALL have port out_tens  output  4  BCD tens digit.
REQ-011 SHALL have port carry  output  1  one-cycle pulse on terminal wrap.
REQ-012 SHALL have port running  output  1  high while the FSM is in RUN.

Function
REQ-013 SHALL pass start_stop through a 2-flop synchronizer (s1, s2) plus a history flop (s3); edge = s2 & ~s3.
REQ-014 SHALL act on a start_stop rising edge at the third rising clk edge after the input is sampled high.
REQ-015 SHALL implement the FSM states IDLE, RUN and STOP.
REQ-016 FSM SHALL take these transitions on edge: IDLE->RUN, RUN->STOP, STOP->RUN.
REQ-017 FSM SHALL go to IDLE with digits 00 when clr=1, from any state.
REQ-018 clr SHALL take priority over edge and tick in the same cycle.
REQ-019 SHALL advance the count only when the current (pre-transition) state is RUN and tick=1; one increment per tick.
REQ-020 When a tick and a state-change edge occur in the same cycle, the tick SHALL be evaluated against the old state.
REQ-021 Increment rules:
- units<9 and not at terminal: units+1.
- units==9 and not at terminal: units=0, tens+1.
- {tens,units}=={MAX_TENS,MAX_UNITS}: both digits=0 and carry=1 for exactly that one cycle.
REQ-022 carry SHALL be 0 in every other cycle, including a cycle where a tick arrives outside RUN.
REQ-023 Digits SHALL never hold a non-BCD value, nor a value above the terminal count.
REQ-024 Digits SHALL hold in IDLE and STOP; STOP->RUN SHALL resume from the held value.
REQ-025 running SHALL be a registered decode of state == RUN, with zero extra latency relative to the state register.
REQ-026 A terminal value with MAX_TENS=0 SHALL wrap from 0,MAX_UNITS directly to 00.

Reset
REQ-027 r=1 SHALL immediately, without clk, force out_units=0, out_tens=0, carry=0, running=0, state=IDLE and s1=s2=s3=0.
REQ-028 r asserted mid-count SHALL discard the count; after r deasserts the block SHALL wait in IDLE for a new start_stop edge.
REQ-029 A start_stop level held high through the release of r SHALL NOT create an edge; s3 tracks s2 from the first clk after release.

Verification
REQ-030 Bench SHALL cover: reset, then press start_stop -> running=1 on the 3rd clk edge; 10 ticks -> tens=1, units=0.
REQ-031 Bench SHALL cover: defaults, count to 99, one tick -> digits 00, carry=1 for exactly one cycle, running stays 1.
REQ-032 Bench SHALL cover: MAX_TENS=5, MAX_UNITS=9, count to 59, one tick -> 00 with a carry pulse; 60 never appears.
REQ-033 Bench SHALL cover: at 37 press start_stop, 5 ticks -> holds 37, running=0; press again, 1 tick -> 38.
REQ-034 Bench SHALL cover: clr=1 with tick=1 and an edge at 42 -> next cycle 00, IDLE, carry=0.
REQ-035 Bench SHALL cover: r pulsed between clk edges at 85 -> outputs 0 before the next clk; ticks are ignored until a new press.
